// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mem_access_unit_if
// | Request, data-memory and response signals of the MEM-stage load/store unit.
// | Revision: 1.0
// +----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_unsigned;
  logic [1:0]        req_width;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              busy;
  logic              dm_req;
  logic              dm_we;
  logic [XLEN-1:0]   dm_addr;
  logic [XLEN/8-1:0] dm_be;
  logic [XLEN-1:0]   dm_wdata;
  logic              dm_ack;
  logic [XLEN-1:0]   dm_rdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [1:0]        rsp_fault;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_unsigned, req_width, req_addr, req_wdata,
    input  dm_ack, dm_rdata,
    output req_ready, busy,
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output rsp_valid, rsp_rdata, rsp_fault
  );

  // The pipeline and data memory around it.
  modport master (
    output req_valid, req_we, req_unsigned, req_width, req_addr, req_wdata,
    output dm_ack, dm_rdata,
    input  req_ready, busy,
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  rsp_valid, rsp_rdata, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mem_access_unit
// | MEM-stage load/store unit: valid/ack data-memory port, byte enables,
// | misalignment check, bus-timeout watchdog and load extension.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_access_unit_if.slave  bus
);

  localparam int c_NB = XLEN / 8;
  localparam int c_OW = $clog2(c_NB);
  localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] c_F_OK  = 2'b00;
  localparam logic [1:0] c_F_MIS = 2'b01;
  localparam logic [1:0] c_F_TO  = 2'b10;
  localparam logic [1:0] c_F_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_unsigned;
  logic [1:0]        r_width;
  logic [c_OW-1:0]   r_off;
  logic [c_CW-1:0]   r_cnt;
  logic              r_dm_req;
  logic              r_dm_we;
  logic [XLEN-1:0]   r_dm_addr;
  logic [c_NB-1:0]   r_dm_be;
  logic [XLEN-1:0]   r_dm_wdata;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic [1:0]        r_rsp_fault;

  logic [c_OW-1:0]   w_off;
  logic [1:0]        w_fault;
  logic [c_NB-1:0]   w_be_base;
  logic [c_NB-1:0]   w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_addr;
  logic [XLEN-1:0]   w_shifted;
  logic              w_sign;
  logic              w_fill;
  logic [XLEN-1:0]   w_load;

  assign w_off   = bus.req_addr[c_OW-1:0];
  assign w_addr  = {bus.req_addr[XLEN-1:c_OW], {c_OW{1'b0}}};
  assign w_wdata = bus.req_wdata << {w_off, 3'b000};
  assign w_be    = bus.req_we ? (w_be_base << w_off) : '0;

  // Illegal width outranks misalignment; dword is only legal on a 64-bit datapath.
  always_comb begin
    w_fault = c_F_OK;
    if (XLEN == 32 && bus.req_width == 2'b11) begin
      w_fault = c_F_ILL;
    end else begin
      case (bus.req_width)
        2'b01:   if (w_off[0] != 1'b0)    w_fault = c_F_MIS;
        2'b10:   if (w_off[1:0] != 2'b00) w_fault = c_F_MIS;
        2'b11:   if (w_off != '0)         w_fault = c_F_MIS;
        default: w_fault = c_F_OK;
      endcase
    end
  end

  always_comb begin
    case (bus.req_width)
      2'b00:   w_be_base = c_NB'(1);
      2'b01:   w_be_base = c_NB'(3);
      2'b10:   w_be_base = c_NB'(15);
      default: w_be_base = '1;
    endcase
  end

  assign w_shifted = bus.dm_rdata >> {r_off, 3'b000};

  // Everything above the access width takes the fill bit.
  always_comb begin
    case (r_width)
      2'b00:   w_sign = w_shifted[7];
      2'b01:   w_sign = w_shifted[15];
      2'b10:   w_sign = w_shifted[31];
      default: w_sign = w_shifted[XLEN-1];
    endcase
    w_fill = w_sign & ~r_unsigned;
    w_load = w_shifted;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= (8 << r_width)) w_load[i] = w_fill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_unsigned  <= 1'b0;
      r_width     <= 2'b00;
      r_off       <= '0;
      r_cnt       <= '0;
      r_dm_req    <= 1'b0;
      r_dm_we     <= 1'b0;
      r_dm_addr   <= '0;
      r_dm_be     <= '0;
      r_dm_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= c_F_OK;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_unsigned <= bus.req_unsigned;
            r_width    <= bus.req_width;
            r_off      <= w_off;
            r_cnt      <= '0;
            if (w_fault != c_F_OK) begin
              // Faulted ops never touch memory.
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= w_fault;
              r_rsp_rdata <= '0;
              r_state     <= S_RESP;
            end else begin
              r_dm_req   <= 1'b1;
              r_dm_we    <= bus.req_we;
              r_dm_addr  <= w_addr;
              r_dm_be    <= w_be;
              r_dm_wdata <= w_wdata;
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (bus.dm_ack) begin
            r_dm_req    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= c_F_OK;
            r_rsp_rdata <= r_dm_we ? '0 : w_load;
            r_state     <= S_RESP;
          end else if (TIMEOUT != 0 && r_cnt == c_TO_LAST) begin
            r_dm_req    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= c_F_TO;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dm_req    = r_dm_req;
  assign bus.dm_we     = r_dm_we;
  assign bus.dm_addr   = r_dm_addr;
  assign bus.dm_be     = r_dm_be;
  assign bus.dm_wdata  = r_dm_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_mem_access_unit
// | Directed bench for a 32-bit (TIMEOUT=4) and a 64-bit instance.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(32)) if32 ();
  mem_access_unit_if #(.XLEN(64)) if64 ();

  mem_access_unit #(.XLEN(32), .TIMEOUT(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  mem_access_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req32(input logic we, input logic uns, input logic [1:0] w,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if32.req_we       = we;
    if32.req_unsigned = uns;
    if32.req_width    = w;
    if32.req_addr     = addr;
    if32.req_wdata    = wdata;
    if32.req_valid    = 1'b1;
    tick();
    if32.req_valid    = 1'b0;
  endtask

  // Zero-wait 64-bit op with address/enable/data/result checks.
  task automatic op64(input string tag, input logic we, input logic uns, input logic [1:0] w,
                      input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                      input logic [63:0] exp_addr, input logic [7:0] exp_be,
                      input logic [63:0] exp_wd, input logic [63:0] exp_rd);
    if64.req_we       = we;
    if64.req_unsigned = uns;
    if64.req_width    = w;
    if64.req_addr     = addr;
    if64.req_wdata    = wdata;
    if64.req_valid    = 1'b1;
    tick();
    if64.req_valid    = 1'b0;
    chk({tag, ".dm_req"}, 64'(if64.dm_req), 64'd1);
    chk({tag, ".dm_addr"}, if64.dm_addr, exp_addr);
    chk({tag, ".dm_be"}, 64'(if64.dm_be), 64'(exp_be));
    if (we) chk({tag, ".dm_wdata"}, if64.dm_wdata, exp_wd);
    if64.dm_rdata = rdata;
    if64.dm_ack   = 1'b1;
    tick();
    if64.dm_ack   = 1'b0;
    chk({tag, ".rsp_valid"}, 64'(if64.rsp_valid), 64'd1);
    chk({tag, ".rsp_rdata"}, if64.rsp_rdata, exp_rd);
    chk({tag, ".rsp_fault"}, 64'(if64.rsp_fault), 64'd0);
    tick();
    chk({tag, ".busy_done"}, 64'(if64.busy), 64'd0);
  endtask

  initial begin
    if32.req_valid = 0; if32.req_we = 0; if32.req_unsigned = 0; if32.req_width = 0;
    if32.req_addr = 0; if32.req_wdata = 0; if32.dm_ack = 0; if32.dm_rdata = 0;
    if64.req_valid = 0; if64.req_we = 0; if64.req_unsigned = 0; if64.req_width = 0;
    if64.req_addr = 0; if64.req_wdata = 0; if64.dm_ack = 0; if64.dm_rdata = 0;

    // Reset state
    @(negedge clk);
    chk("rst.dm_req", 64'(if32.dm_req), 64'd0);
    chk("rst.busy", 64'(if32.busy), 64'd0);
    chk("rst.rsp_valid", 64'(if32.rsp_valid), 64'd0);
    chk("rst.rsp_rdata", 64'(if32.rsp_rdata), 64'd0);
    chk("rst.rsp_fault", 64'(if32.rsp_fault), 64'd0);
    chk("rst.dm_be", 64'(if32.dm_be), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst.req_ready", 64'(if32.req_ready), 64'd1);

    // LB 0x1003, zero wait
    req32(1'b0, 1'b0, 2'b00, 32'h1003, 32'h0);
    chk("lb.dm_req", 64'(if32.dm_req), 64'd1);
    chk("lb.dm_addr", 64'(if32.dm_addr), 64'h1000);
    chk("lb.dm_be", 64'(if32.dm_be), 64'd0);
    chk("lb.dm_we", 64'(if32.dm_we), 64'd0);
    chk("lb.req_ready", 64'(if32.req_ready), 64'd0);
    chk("lb.rsp_early", 64'(if32.rsp_valid), 64'd0);
    if32.dm_rdata = 32'h80FF1234;
    if32.dm_ack   = 1'b1;
    tick();
    if32.dm_ack   = 1'b0;
    chk("lb.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("lb.rsp_rdata", 64'(if32.rsp_rdata), 64'hFFFFFF80);
    chk("lb.rsp_fault", 64'(if32.rsp_fault), 64'd0);
    chk("lb.dm_req_drop", 64'(if32.dm_req), 64'd0);
    chk("lb.busy_resp", 64'(if32.busy), 64'd1);
    tick();
    chk("lb.rsp_pulse", 64'(if32.rsp_valid), 64'd0);
    chk("lb.busy_done", 64'(if32.busy), 64'd0);
    chk("lb.ready", 64'(if32.req_ready), 64'd1);
    chk("lb.rsp_hold", 64'(if32.rsp_rdata), 64'hFFFFFF80);

    // LW misaligned 0x1001
    req32(1'b0, 1'b0, 2'b10, 32'h1001, 32'h0);
    chk("lwmis.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("lwmis.rsp_fault", 64'(if32.rsp_fault), 64'd1);
    chk("lwmis.rsp_rdata", 64'(if32.rsp_rdata), 64'd0);
    chk("lwmis.dm_req", 64'(if32.dm_req), 64'd0);
    chk("lwmis.busy", 64'(if32.busy), 64'd1);
    tick();
    chk("lwmis.dm_req2", 64'(if32.dm_req), 64'd0);
    chk("lwmis.busy_done", 64'(if32.busy), 64'd0);

    // Width 11 on XLEN=32, aligned store
    req32(1'b1, 1'b0, 2'b11, 32'h3000, 32'h12345678);
    chk("ill.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("ill.rsp_fault", 64'(if32.rsp_fault), 64'd3);
    chk("ill.dm_req", 64'(if32.dm_req), 64'd0);
    tick();

    // SH 0x2002 with two wait states
    if32.dm_rdata = 32'hDEADBEEF;
    req32(1'b1, 1'b0, 2'b01, 32'h2002, 32'h0000ABCD);
    for (int i = 0; i < 3; i++) begin
      chk("sh.dm_req", 64'(if32.dm_req), 64'd1);
      chk("sh.dm_we", 64'(if32.dm_we), 64'd1);
      chk("sh.dm_be", 64'(if32.dm_be), 64'hC);
      chk("sh.dm_wdata_hi", 64'(if32.dm_wdata[31:16]), 64'hABCD);
      chk("sh.busy", 64'(if32.busy), 64'd1);
      if32.dm_ack = (i == 2);
      tick();
    end
    if32.dm_ack = 1'b0;
    chk("sh.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("sh.busy_resp", 64'(if32.busy), 64'd1);
    chk("sh.rsp_rdata", 64'(if32.rsp_rdata), 64'd0);
    chk("sh.rsp_fault", 64'(if32.rsp_fault), 64'd0);
    tick();
    chk("sh.busy_done", 64'(if32.busy), 64'd0);

    // Timeout: no ack, dm_req for exactly 4 cycles
    req32(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to.dm_req", 64'(if32.dm_req), 64'd1);
      chk("to.rsp_early", 64'(if32.rsp_valid), 64'd0);
      tick();
    end
    chk("to.dm_req_drop", 64'(if32.dm_req), 64'd0);
    chk("to.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("to.rsp_fault", 64'(if32.rsp_fault), 64'd2);
    chk("to.rsp_rdata", 64'(if32.rsp_rdata), 64'd0);
    tick();

    // Ack on the 4th ACCESS cycle wins over timeout
    if32.dm_rdata = 32'h12345678;
    req32(1'b0, 1'b0, 2'b10, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to4.dm_req", 64'(if32.dm_req), 64'd1);
      if32.dm_ack = (i == 3);
      tick();
    end
    if32.dm_ack = 1'b0;
    chk("to4.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("to4.rsp_fault", 64'(if32.rsp_fault), 64'd0);
    chk("to4.rsp_rdata", 64'(if32.rsp_rdata), 64'h12345678);
    tick();

    // 64-bit datapath
    op64("lhu64", 1'b0, 1'b1, 2'b01, 64'h4006, 64'h0, 64'h8001_0000_0000_0000,
         64'h4000, 8'h00, 64'h0, 64'h0000_0000_0000_8001);
    op64("lh64", 1'b0, 1'b0, 2'b01, 64'h4006, 64'h0, 64'h8001_0000_0000_0000,
         64'h4000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    op64("lw64", 1'b0, 1'b0, 2'b10, 64'h4004, 64'h0, 64'h8000_0000_0000_0000,
         64'h4000, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
    op64("sd64", 1'b1, 1'b0, 2'b11, 64'h4008, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF,
         64'h4008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
    op64("sb64", 1'b1, 1'b0, 2'b00, 64'h400D, 64'h0000_0000_0000_00AB, 64'h0,
         64'h4008, 8'h20, 64'h0000_AB00_0000_0000, 64'h0);

    if64.req_we = 1'b0; if64.req_unsigned = 1'b0; if64.req_width = 2'b11;
    if64.req_addr = 64'h4004; if64.req_valid = 1'b1;
    tick();
    if64.req_valid = 1'b0;
    chk("ldmis64.rsp_fault", 64'(if64.rsp_fault), 64'd1);
    chk("ldmis64.dm_req", 64'(if64.dm_req), 64'd0);
    tick();

    // Reset in the middle of ACCESS
    req32(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    chk("mid.dm_req", 64'(if32.dm_req), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid.dm_req_drop", 64'(if32.dm_req), 64'd0);
    chk("mid.busy_drop", 64'(if32.busy), 64'd0);
    chk("mid.rsp_valid", 64'(if32.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mid.rsp_none", 64'(if32.rsp_valid), 64'd0);
    chk("mid.ready", 64'(if32.req_ready), 64'd1);

    if32.dm_rdata = 32'hCAFEF00D;
    req32(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    chk("post.dm_req", 64'(if32.dm_req), 64'd1);
    chk("post.dm_addr", 64'(if32.dm_addr), 64'h0);
    if32.dm_ack = 1'b1;
    tick();
    if32.dm_ack = 1'b0;
    chk("post.rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("post.rsp_rdata", 64'(if32.rsp_rdata), 64'hCAFEF00D);
    chk("post.rsp_fault", 64'(if32.rsp_fault), 64'd0);
    tick();
    chk("post.busy_done", 64'(if32.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
